// File: rtl/fetch_decode_queue_pkg.sv
// Shared pipeline definitions: entry payload, NOP encoding and counter sizing helper.
package fetch_decode_queue_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_decode_queue_ram.sv
// Entry storage for the IF/ID queue: one write port on the falling edge, asynchronous read.
module sync_fifo_ram
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned WIDTH = PC_W + INSTR_W,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// IF/ID boundary FIFO of {pc, instr} pairs with stall/halt/flush semantics and last-PC retention.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_instr,
  output logic              o_full,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] last_pc;

  logic              pop_c;
  logic              push_ok_c;
  logic [ENT_W-1:0]  head_c;
  logic [ADDR_W-1:0] head_pc_c;
  logic [DATA_W-1:0] head_instr_c;

  assign o_valid = (count != '0);
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_count = count;

  // A push into a full queue is still accepted when the head leaves on the same edge.
  assign pop_c     = o_valid & ~i_stall & ~i_halt;
  assign push_ok_c = i_push & ~i_halt & ~i_flush & (~o_full | pop_c);

  sync_fifo_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok_c & ~rst),
    .waddr (wr_ptr),
    .wdata ({i_pc, i_instr}),
    .raddr (rd_ptr),
    .rdata (head_c)
  );

  assign head_pc_c    = head_c[ENT_W-1:DATA_W];
  assign head_instr_c = head_c[DATA_W-1:0];

  // Priority: reset, then halt (freezes everything including flush), then flush, then push/pop.
  always_ff @(negedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      last_pc <= '0;
    end else if (!i_halt) begin
      if (i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c) begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          last_pc <= head_pc_c;
        end
        if (push_ok_c && !pop_c) begin
          count <= count + CNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Empty queue shows the last consumed PC with a NOP so decode sees a bubble.
  assign o_pc    = o_valid ? head_pc_c : last_pc;
  assign o_instr = o_valid ? head_instr_c : DATA_W'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: directed pushes feed an expected queue, a monitor checks heads.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush, i_stall, i_halt, i_push;
  logic [31:0]   i_pc, i_instr;
  logic          o_full, o_valid;
  logic [31:0]   o_pc, o_instr;
  logic [CW-1:0] o_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  fetch_entry_t expq[$];

  fetch_decode_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_stall (i_stall),
    .i_halt  (i_halt),
    .i_push  (i_push),
    .i_pc    (i_pc),
    .i_instr (i_instr),
    .o_full  (o_full),
    .o_valid (o_valid),
    .o_pc    (o_pc),
    .o_instr (o_instr),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable between falling edges, so sample on the rising edge.
  always @(posedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (o_count !== CW'(expq.size())) begin
        errors++;
        $display("FAIL count: got %0d expected %0d", o_count, expq.size());
      end
    end
    if (rst || (i_flush && !i_halt)) begin
      expq.delete();
    end else if (mon_en && o_valid && !i_stall && !i_halt) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %0h expected empty queue", o_pc);
      end else begin
        fetch_entry_t e;
        e = expq.pop_front();
        checks++;
        if (o_pc !== e.pc || o_instr !== e.instr) begin
          errors++;
          $display("FAIL head: got %0h/%0h expected %0h/%0h", o_pc, o_instr, e.pc, e.instr);
        end
      end
    end
  end

  // Drive one cycle just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic psh, input logic [31:0] pc, input logic [31:0] ins,
                     input logic acc, input logic stl, input logic hlt, input logic fl);
    i_push  = psh;
    i_pc    = pc;
    i_instr = ins;
    i_stall = stl;
    i_halt  = hlt;
    i_flush = fl;
    @(negedge clk);
    #1;
    if (psh && acc) expq.push_back('{pc: pc, instr: ins});
  endtask

  task automatic check_state(input string tag, input logic [31:0] cnt, input logic full,
                             input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, "_count"}, 32'(o_count), cnt);
    check({tag, "_full"},  32'(o_full),  32'(full));
    check({tag, "_valid"}, 32'(o_valid), 32'(vld));
    check({tag, "_pc"},    o_pc,         pc);
    check({tag, "_instr"}, o_instr,      ins);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_stall = 1'b0; i_halt = 1'b0;
    i_push = 1'b0; i_pc = '0; i_instr = '0;
    @(negedge clk); @(negedge clk); #1;
    check_state("reset", 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fill under stall, drop a fifth push, then drain in order.
    cyc(1, 32'h00, 32'h0000_0013, 1, 1, 0, 0);
    check_state("push1", 1, 0, 1, 32'h00, 32'h0000_0013);
    cyc(1, 32'h04, 32'h0040_0093, 1, 1, 0, 0);
    cyc(1, 32'h08, 32'h0080_0113, 1, 1, 0, 0);
    cyc(1, 32'h0C, 32'h00C0_0193, 1, 1, 0, 0);
    check_state("filled", 4, 1, 1, 32'h00, 32'h0000_0013);
    cyc(1, 32'h10, 32'h0100_0213, 0, 1, 0, 0);
    check_state("drop5", 4, 1, 1, 32'h00, 32'h0000_0013);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    check_state("drained", 0, 0, 0, 32'h0C, 32'h0);

    // Flush with a concurrent push and no stall: push and pop both discarded, last PC kept.
    cyc(1, 32'h14, 32'h0140_0293, 1, 1, 0, 0);
    cyc(1, 32'h18, 32'h0180_0313, 1, 1, 0, 0);
    cyc(1, 32'h1C, 32'h01C0_0393, 1, 1, 0, 0);
    check("pre_flush_count", 32'(o_count), 3);
    cyc(1, 32'h20, 32'h0200_0413, 0, 0, 0, 1);
    check_state("flushed", 0, 0, 0, 32'h0C, 32'h0);
    cyc(1, 32'h40, 32'h0400_0493, 1, 1, 0, 0);
    check_state("post_flush", 1, 0, 1, 32'h40, 32'h0400_0493);

    // Halt freezes flush and push; releasing halt with flush still high empties the queue.
    cyc(1, 32'h44, 32'h0440_0513, 1, 1, 0, 0);
    check("pre_halt_count", 32'(o_count), 2);
    cyc(1, 32'h48, 32'h0480_0593, 0, 0, 1, 1);
    check_state("halted", 2, 0, 1, 32'h40, 32'h0400_0493);
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 1);
    check_state("halt_release", 0, 0, 0, 32'h0C, 32'h0);

    // Push with pop at full; pointers wrap and the new entry queues behind the older three.
    cyc(1, 32'h60, 32'h0600_0613, 1, 1, 0, 0);
    cyc(1, 32'h64, 32'h0640_0693, 1, 1, 0, 0);
    cyc(1, 32'h68, 32'h0680_0713, 1, 1, 0, 0);
    cyc(1, 32'h6C, 32'h06C0_0793, 1, 1, 0, 0);
    check_state("full2", 4, 1, 1, 32'h60, 32'h0600_0613);
    cyc(1, 32'h50, 32'h0500_0593, 1, 0, 0, 0);
    check_state("full_pushpop", 4, 1, 1, 32'h64, 32'h0640_0693);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    check_state("wrap_drained", 0, 0, 0, 32'h50, 32'h0);

    // Synchronous reset overrides push, halt and flush.
    cyc(1, 32'h70, 32'h0700_0813, 1, 1, 0, 0);
    cyc(1, 32'h74, 32'h0740_0893, 1, 1, 0, 0);
    cyc(1, 32'h78, 32'h0780_0913, 1, 1, 0, 0);
    check("pre_reset_count", 32'(o_count), 3);
    rst = 1'b1;
    cyc(1, 32'h7C, 32'h07C0_0993, 0, 0, 1, 1);
    check_state("mid_reset", 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    cyc(1, 32'h80, 32'h0800_0A13, 1, 1, 0, 0);
    check_state("after_reset", 1, 0, 1, 32'h80, 32'h0800_0A13);
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    check_state("final", 0, 0, 0, 32'h80, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
